ndet: RTL and testbench
=======================

NDET -- requirements
Module: ndet

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent input bits monitored.
REQ-002 Parameter: CNT_W, default 8, width of the falling-edge event counter.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rstn  input  1  reset, synchronous, active-low.
REQ-005 Port: d  input  WIDTH  monitored signal, sampled each rising clk edge.
REQ-006 Port: n_edge  output  WIDTH  per-bit falling-edge indication.
REQ-007 Port: p_edge  output  WIDTH  per-bit rising-edge indication.
REQ-008 Port: n_cnt  output  CNT_W  count of clock cycles in which n_edge[0] was high.
REQ-009 Single clock domain; d is synchronous to clk, no internal synchronizer.

Function
REQ-010 The block SHALL hold a registered copy d_q of d, loaded with d on every rising clk edge while rstn=1.
REQ-011 n_edge[i] SHALL be combinational: d_q[i]=1 AND d[i]=0 AND rstn=1.
REQ-012 p_edge[i] SHALL be combinational: d_q[i]=0 AND d[i]=1 AND rstn=1.
REQ-013 Latency: n_edge asserts in the same cycle d falls (zero clock latency), with no clock edge required.
REQ-014 Pulse width: n_edge stays high from the fall of d until the next rising clk edge, which loads d_q=0; a held-low d yields exactly one pulse.
REQ-015 A d pulse that goes high and returns low between two rising edges SHALL produce no registered effect; combinational glitches on the outputs are permitted.
REQ-016 Per-bit independence: each bit i uses only d[i] and d_q[i].
REQ-017 n_edge and p_edge SHALL never be high simultaneously for the same bit.
REQ-018 n_cnt SHALL increment by 1 on each rising clk edge at which n_edge[0]=1 and rstn=1.
REQ-019 n_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 d constant for any number of cycles SHALL leave n_edge=0, p_edge=0, and n_cnt unchanged.

Reset
REQ-021 Reset acts only on a rising clk edge with rstn=0; it SHALL load d_q to all zeros and n_cnt to 0.
REQ-022 While rstn=0, n_edge and p_edge SHALL be 0 regardless of d or d_q, including before the first clock edge.
REQ-023 The first rising edge after rstn returns to 1 SHALL load d_q=d.
REQ-024 Because d_q resets to 0, a d held high through reset release produces exactly one p_edge pulse and no n_edge.
REQ-025 Reset asserted mid-pulse SHALL immediately force the outputs to 0, clear the state at the next edge, and leave no pending edge behind.

Verification
REQ-026 Reset: rstn=0 for 1 edge, d toggling -> n_edge=0, p_edge=0, n_cnt=0 throughout.
REQ-027 Single fall: rstn=1, d=1 for 2 cycles, then d=0 mid-cycle -> n_edge=1 immediately, 0 after the next edge, n_cnt=1.
REQ-028 Rise: d goes 0->1 -> p_edge=1 until the next edge, n_edge=0, n_cnt unchanged.
REQ-029 Repeated: d high 1 cycle / low 1 cycle, repeated 3 times -> 3 n_edge pulses of one partial cycle each, n_cnt=3.
REQ-030 Saturation: CNT_W=2, 5 falling edges -> n_cnt reaches 3 and holds 3.
REQ-031 Mid-operation reset: d falls, rstn=0 in the same cycle -> n_edge forced 0, n_cnt=0 after the edge; with d=1 on release, p_edge pulses once.

Source files
------------

// File: rtl/ndet.sv
// Edge detector with a falling-edge event counter.
// Each bit of d is compared against its registered copy from the previous
// rising clk edge. Edge indications are combinational: they appear as soon
// as d changes and last until the next edge loads the new value. n_cnt
// counts the edges at which bit 0 shows a falling edge and saturates at
// its maximum value.
module ndet #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] n_edge,
    output logic [WIDTH-1:0] p_edge,
    output logic [CNT_W-1:0] n_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_d_q;
    logic [CNT_W-1:0] r_n_cnt;
    logic             w_cnt_full;

    // Edge decode is gated by rstn so outputs are quiet during reset, even
    // before the first clock edge has loaded r_d_q.
    always_comb begin
        n_edge = '0;
        p_edge = '0;
        if (rstn) begin
            n_edge = r_d_q & ~d;
            p_edge = ~r_d_q & d;
        end
    end

    assign w_cnt_full = (r_n_cnt == CNT_MAX);
    assign n_cnt      = r_n_cnt;

    // Sample d each edge; count bit-0 falling edges, holding at the maximum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_d_q   <= '0;
            r_n_cnt <= '0;
        end else begin
            r_d_q <= d;
            if (n_edge[0] && !w_cnt_full) begin
                r_n_cnt <= r_n_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ndet.sv
// Self-checking bench for ndet. A behavioural model tracks the value of d
// seen at the last rising edge and the number of bit-0 falls, and predicts
// the edge outputs and the counter. A second instance with a 2-bit counter
// exercises saturation.
module tb_ndet;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int CW_S = 2;

    logic            clk;
    logic            rstn;
    logic [W-1:0]    d;
    logic [W-1:0]    n_edge;
    logic [W-1:0]    p_edge;
    logic [CW-1:0]   n_cnt;
    logic [0:0]      d_s;
    logic [0:0]      n_edge_s;
    logic [0:0]      p_edge_s;
    logic [CW_S-1:0] n_cnt_s;

    int pass_cnt;
    int total_cnt;

    // reference model state
    bit [W-1:0] m_prev;
    int         m_cnt;
    bit         s_prev;
    int         s_cnt;

    ndet #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .d      (d),
        .n_edge (n_edge),
        .p_edge (p_edge),
        .n_cnt  (n_cnt)
    );

    ndet #(.WIDTH(1), .CNT_W(CW_S)) dut_s (
        .clk    (clk),
        .rstn   (rstn),
        .d      (d_s),
        .n_edge (n_edge_s),
        .p_edge (p_edge_s),
        .n_cnt  (n_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_fall();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            r[i] = (rstn === 1'b1) && (m_prev[i] == 1'b1) && (d[i] == 1'b0);
        return r;
    endfunction

    function automatic logic [W-1:0] exp_rise();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            r[i] = (rstn === 1'b1) && (m_prev[i] == 1'b0) && (d[i] == 1'b1);
        return r;
    endfunction

    // drive new inputs mid-cycle and let combinational outputs settle
    task automatic apply(input logic [W-1:0] dv, input logic rv);
        @(negedge clk);
        d    = dv;
        rstn = rv;
        #1;
    endtask

    // advance one rising edge and update the model with what the edge saw
    task automatic tick();
        @(posedge clk);
        if (rstn !== 1'b1) begin
            m_prev = '0;
            m_cnt  = 0;
            s_prev = 1'b0;
            s_cnt  = 0;
        end else begin
            if (m_prev[0] && !d[0]) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            if (s_prev && !d_s[0])  s_cnt = (s_cnt + 1 > 3) ? 3 : s_cnt + 1;
            m_prev = d;
            s_prev = d_s[0];
        end
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] dv;
        rstn = 1'b0;
        d    = 4'b1010;
        d_s  = 1'b1;
        #1;
        total_cnt++;
        if (n_edge !== '0 || p_edge !== '0 || n_edge_s !== 1'b0 || p_edge_s !== 1'b0)
            $display("FAIL pre_edge_reset: n_edge=%b p_edge=%b exp 0", n_edge, p_edge);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            dv = W'($urandom);
            apply(dv, 1'b0);
            d_s = dv[0];
            #1;
            total_cnt++;
            if (n_edge !== '0 || p_edge !== '0)
                $display("FAIL reset_edges: n_edge=%b p_edge=%b exp 0", n_edge, p_edge);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (n_cnt !== '0 || n_cnt_s !== '0 || n_edge !== '0 || p_edge !== '0)
                $display("FAIL reset_cnt: n_cnt=%0d n_cnt_s=%0d exp 0", n_cnt, n_cnt_s);
            else pass_cnt++;
        end
        d_s = 1'b0;
    endtask

    task automatic test_single_fall();
        int c0;
        apply(4'b0001, 1'b1);
        total_cnt++;
        if (p_edge !== 4'b0001 || n_edge !== 4'b0000)
            $display("FAIL release_rise: p_edge=%b n_edge=%b exp p=0001 n=0000", p_edge, n_edge);
        else pass_cnt++;
        tick();
        apply(4'b0001, 1'b1);
        tick();
        c0 = m_cnt;
        apply(4'b0000, 1'b1);
        total_cnt++;
        if (n_edge !== 4'b0001 || p_edge !== 4'b0000)
            $display("FAIL fall_immediate: n_edge=%b p_edge=%b exp n=0001 p=0000", n_edge, p_edge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (n_edge !== 4'b0000 || n_cnt !== CW'(c0 + 1) || n_cnt !== CW'(m_cnt))
            $display("FAIL fall_after_edge: n_edge=%b n_cnt=%0d exp n=0000 cnt=%0d", n_edge, n_cnt, c0 + 1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (n_edge !== 4'b0000 || n_cnt !== CW'(c0 + 1))
            $display("FAIL fall_held_low: n_edge=%b n_cnt=%0d exp n=0000 cnt=%0d", n_edge, n_cnt, c0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_rise();
        int c0;
        c0 = m_cnt;
        apply(4'b0110, 1'b1);
        total_cnt++;
        if (p_edge !== 4'b0110 || n_edge !== 4'b0000)
            $display("FAIL rise: p_edge=%b n_edge=%b exp p=0110 n=0000", p_edge, n_edge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (p_edge !== 4'b0000 || n_cnt !== CW'(c0))
            $display("FAIL rise_after_edge: p_edge=%b n_cnt=%0d exp p=0000 cnt=%0d", p_edge, n_cnt, c0);
        else pass_cnt++;
    endtask

    task automatic test_repeated();
        int c0;
        int pulses;
        c0 = m_cnt;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            apply(4'b0001, 1'b1);
            tick();
            apply(4'b0000, 1'b1);
            if (n_edge[0] === 1'b1) pulses++;
            tick();
            if (n_edge[0] !== 1'b0) pulses += 10;
        end
        total_cnt++;
        if (pulses != 3 || n_cnt !== CW'(c0 + 3))
            $display("FAIL repeated: pulses=%0d n_cnt=%0d exp pulses=3 cnt=%0d", pulses, n_cnt, c0 + 3);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int c0;
        apply(4'b0000, 1'b1);
        tick();
        c0 = m_cnt;
        @(negedge clk);
        d = 4'b0011;
        #1;
        d = 4'b0000;
        #1;
        tick();
        total_cnt++;
        if (n_cnt !== CW'(c0) || n_edge !== '0 || p_edge !== '0)
            $display("FAIL glitch: n_cnt=%0d n_edge=%b p_edge=%b exp cnt=%0d edges 0", n_cnt, n_edge, p_edge, c0);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int falls;
        falls = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); d_s = 1'b1; #1;
            tick();
            @(negedge clk); d_s = 1'b0; #1;
            tick();
            falls++;
            total_cnt++;
            if (n_cnt_s !== CW_S'((falls > 3) ? 3 : falls) || n_cnt_s !== CW_S'(s_cnt))
                $display("FAIL saturation: falls=%0d n_cnt_s=%0d exp %0d", falls, n_cnt_s, (falls > 3) ? 3 : falls);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        apply(4'b1111, 1'b1);
        tick();
        apply(4'b0000, 1'b0);
        total_cnt++;
        if (n_edge !== '0 || p_edge !== '0)
            $display("FAIL mid_reset_force: n_edge=%b p_edge=%b exp 0", n_edge, p_edge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (n_cnt !== '0)
            $display("FAIL mid_reset_cnt: n_cnt=%0d exp 0", n_cnt);
        else pass_cnt++;
        apply(4'b1111, 1'b1);
        total_cnt++;
        if (p_edge !== 4'b1111 || n_edge !== '0)
            $display("FAIL mid_reset_release: p_edge=%b n_edge=%b exp p=1111 n=0000", p_edge, n_edge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (p_edge !== '0 || n_edge !== '0 || n_cnt !== '0)
            $display("FAIL mid_reset_single: p_edge=%b n_edge=%b n_cnt=%0d exp 0", p_edge, n_edge, n_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] dv;
        logic         rv;
        for (int k = 0; k < 60; k++) begin
            dv = W'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            apply(dv, rv);
            total_cnt++;
            if (n_edge !== exp_fall() || p_edge !== exp_rise() || n_cnt !== CW'(m_cnt) || (n_edge & p_edge) !== '0)
                $display("FAIL random_mid: k=%0d n_edge=%b p_edge=%b n_cnt=%0d exp n=%b p=%b cnt=%0d",
                         k, n_edge, p_edge, n_cnt, exp_fall(), exp_rise(), m_cnt);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (n_cnt !== CW'(m_cnt) || n_edge !== exp_fall() || p_edge !== exp_rise())
                $display("FAIL random_edge: k=%0d n_cnt=%0d n_edge=%b p_edge=%b exp cnt=%0d n=%b p=%b",
                         k, n_cnt, n_edge, p_edge, m_cnt, exp_fall(), exp_rise());
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_prev    = '0;
        m_cnt     = 0;
        s_prev    = 1'b0;
        s_cnt     = 0;
        test_reset();
        test_single_fall();
        test_rise();
        test_repeated();
        test_glitch();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
